// File: rtl/regfile_wb_arb.sv
// Arbitrates one register-file write port between pipeline writeback (always wins) and a 2-entry mul/div result FIFO.
// Optional same-cycle md bypass when the FIFO is empty and wb is idle: define WB_ARB_BYPASS_EN.
module regfile_wb_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic        md_valid,
  input  logic [4:0]  md_waddr,
  input  logic [31:0] md_wdata,
  output logic        md_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic        pend1,
  output logic        pend2,
  output logic        stall_o
);

  localparam logic [3:0] STARVE_TH = 4'(STARVE_MAX);

  logic [4:0]  addr_q [2];
  logic [31:0] data_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  starve_q, starve_d;

  logic empty, full, wb_win, md_acc, byp, enq, deq;

  assign empty    = (cnt_q == 2'd0);
  assign full     = (cnt_q == 2'd2);
  assign wb_win   = wb_we && (wb_waddr != 5'd0);
  assign md_ready = resetn && !full;
  // Results targeting r0 are accepted but never stored.
  assign md_acc   = md_valid && md_ready && (md_waddr != 5'd0);

`ifdef WB_ARB_BYPASS_EN
  assign byp = md_acc && empty && !wb_win;
`else
  assign byp = 1'b0;
`endif

  assign enq = md_acc && !byp;
  assign deq = resetn && !wb_win && !empty;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (resetn) begin
      if (wb_win) begin
        rf_we    = 1'b1;
        rf_waddr = wb_waddr;
        rf_wdata = wb_wdata;
      end else if (!empty) begin
        rf_we    = 1'b1;
        rf_waddr = addr_q[rd_ptr_q];
        rf_wdata = data_q[rd_ptr_q];
      end else if (byp) begin
        rf_we    = 1'b1;
        rf_waddr = md_waddr;
        rf_wdata = md_wdata;
      end
    end
  end

  // The head entry still counts as pending during the cycle it is being written.
  function automatic logic hit(input logic [4:0] ra);
    logic h0, h1;
    h0 = (cnt_q != 2'd0) && (addr_q[rd_ptr_q] == ra);
    h1 = (cnt_q == 2'd2) && (addr_q[~rd_ptr_q] == ra);
    return (ra != 5'd0) && (h0 || h1);
  endfunction

  assign pend1   = resetn && hit(raddr1);
  assign pend2   = resetn && hit(raddr2);
  assign stall_o = (starve_q >= STARVE_TH);

  always_comb begin
    cnt_d = cnt_q;
    case ({enq, deq})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (empty || deq)
      starve_d = 4'd0;
    else if (wb_win && (starve_q != 4'd15))
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      starve_q  <= 4'd0;
      addr_q[0] <= 5'd0;
      addr_q[1] <= 5'd0;
      data_q[0] <= 32'd0;
      data_q[1] <= 32'd0;
    end else begin
      if (enq) begin
        addr_q[wr_ptr_q] <= md_waddr;
        data_q[wr_ptr_q] <= md_wdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (deq)
        rd_ptr_q <= ~rd_ptr_q;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb; inputs change 1 time unit after posedge, outputs sampled before the next edge.
module tb_regfile_wb_arb;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        md_valid;
  logic [4:0]  md_waddr;
  logic [31:0] md_wdata;
  logic        md_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  raddr1, raddr2;
  logic        pend1, pend2, stall_o;

  int total = 0;
  int bad   = 0;

  regfile_wb_arb #(.STARVE_MAX(4)) dut (
    .clk(clk), .resetn(resetn),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .md_valid(md_valid), .md_waddr(md_waddr), .md_wdata(md_wdata),
    .md_ready(md_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .raddr1(raddr1), .raddr2(raddr2),
    .pend1(pend1), .pend2(pend2), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    wb_we = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'd0;
    md_valid = 1'b0; md_waddr = 5'd0; md_wdata = 32'd0;
    raddr1 = 5'd0; raddr2 = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'hAAAA;
    md_valid = 1'b1; md_waddr = 5'd3; md_wdata = 32'hBBBB;
    raddr1 = 5'd3; raddr2 = 5'd3;
    #1;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rst_rf_we got=%0h exp=0", rf_we); end
    total++; if (md_ready !== 1'b0) begin bad++; $display("FAIL rst_md_ready got=%0h exp=0", md_ready); end
    total++; if (pend1 !== 1'b0 || pend2 !== 1'b0) begin bad++; $display("FAIL rst_pend got=%0h%0h exp=00", pend1, pend2); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", stall_o); end
    tick(); tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rst_hold_we got=%0h exp=0", rf_we); end
    idle();
    resetn = 1'b1;
    #1;
    total++; if (md_ready !== 1'b1) begin bad++; $display("FAIL rst_rel_ready got=%0h exp=1", md_ready); end
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rst_rel_we got=%0h exp=0", rf_we); end
  endtask

  task automatic test_md_basic();
    md_valid = 1'b1; md_waddr = 5'd5; md_wdata = 32'h1234;
    #1;
    total++; if (md_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%0h exp=1", md_ready); end
`ifdef WB_ARB_BYPASS_EN
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
      bad++; $display("FAIL basic_bypass got=%0h/%0d/%0h exp=1/5/1234", rf_we, rf_waddr, rf_wdata); end
`else
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL basic_same_cycle got=%0h exp=0", rf_we); end
`endif
    tick();
    md_valid = 1'b0; md_waddr = 5'd0; md_wdata = 32'd0;
    #1;
`ifdef WB_ARB_BYPASS_EN
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL basic_next got=%0h exp=0", rf_we); end
`else
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
      bad++; $display("FAIL basic_next got=%0h/%0d/%0h exp=1/5/1234", rf_we, rf_waddr, rf_wdata); end
`endif
    tick();
    total++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      bad++; $display("FAIL basic_drained got=%0h/%0d/%0h exp=0/0/0", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_md_zero();
    md_valid = 1'b1; md_waddr = 5'd0; md_wdata = 32'hDEAD;
    #1;
    total++; if (md_ready !== 1'b1 || rf_we !== 1'b0) begin
      bad++; $display("FAIL mdzero_accept got=%0h/%0h exp=1/0", md_ready, rf_we); end
    tick();
    idle();
    #1;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL mdzero_discard got=%0h exp=0", rf_we); end
    tick();
  endtask

  task automatic test_starve();
    wb_we = 1'b1; wb_waddr = 5'd10; wb_wdata = 32'h100;
    md_valid = 1'b1; md_waddr = 5'd3; md_wdata = 32'hA3;
    #1;
    total++; if (rf_waddr !== 5'd10 || rf_wdata !== 32'h100) begin
      bad++; $display("FAIL starve_wb_wins got=%0d/%0h exp=10/100", rf_waddr, rf_wdata); end
    tick();
    wb_wdata = 32'h101; md_waddr = 5'd4; md_wdata = 32'hA4; raddr1 = 5'd3;
    #1;
    total++; if (pend1 !== 1'b1) begin bad++; $display("FAIL starve_pend1_r3 got=%0h exp=1", pend1); end
    tick();
    md_valid = 1'b0; wb_wdata = 32'h102; raddr2 = 5'd4;
    #1;
    total++; if (md_ready !== 1'b0) begin bad++; $display("FAIL starve_full_ready got=%0h exp=0", md_ready); end
    total++; if (pend1 !== 1'b1 || pend2 !== 1'b1) begin bad++; $display("FAIL starve_pend_both got=%0h%0h exp=11", pend1, pend2); end
    tick(); tick();
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL starve_stall_early got=%0h exp=0", stall_o); end
    tick();
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL starve_stall got=%0h exp=1", stall_o); end
    total++; if (rf_waddr !== 5'd10) begin bad++; $display("FAIL starve_wb_prio got=%0d exp=10", rf_waddr); end
  endtask

  task automatic test_reset_mid();
    md_valid = 1'b1; md_waddr = 5'd6; md_wdata = 32'h66;
    #2;
    resetn = 1'b0;
    #1;
    total++; if (rf_we !== 1'b0 || md_ready !== 1'b0 || pend1 !== 1'b0 || pend2 !== 1'b0 || stall_o !== 1'b0) begin
      bad++; $display("FAIL midrst_outs got=%0h%0h%0h%0h%0h exp=00000", rf_we, md_ready, pend1, pend2, stall_o); end
    tick();
    idle();
    resetn = 1'b1;
    raddr1 = 5'd3; raddr2 = 5'd4;
    #1;
    total++; if (pend1 !== 1'b0 || pend2 !== 1'b0) begin bad++; $display("FAIL midrst_pend got=%0h%0h exp=00", pend1, pend2); end
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL midrst_nowrite got=%0h exp=0", rf_we); end
    idle();
    tick();
  endtask

  task automatic test_wb_zero();
    wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'h99;
    md_valid = 1'b1; md_waddr = 5'd7; md_wdata = 32'h77;
    tick();
    md_valid = 1'b0; md_waddr = 5'd0; md_wdata = 32'd0;
    wb_waddr = 5'd0; wb_wdata = 32'hFFFF; raddr1 = 5'd7;
    #1;
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h77) begin
      bad++; $display("FAIL wbzero_head got=%0h/%0d/%0h exp=1/7/77", rf_we, rf_waddr, rf_wdata); end
    total++; if (pend1 !== 1'b1) begin bad++; $display("FAIL wbzero_pend_deq got=%0h exp=1", pend1); end
    tick();
    total++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || pend1 !== 1'b0) begin
      bad++; $display("FAIL wbzero_empty got=%0h/%0d/%0h exp=0/0/0", rf_we, rf_waddr, pend1); end
    idle();
    tick();
  endtask

  task automatic test_full_order();
    wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'h1;
    md_valid = 1'b1; md_waddr = 5'd11; md_wdata = 32'hA1;
    tick();
    md_waddr = 5'd12; md_wdata = 32'hA2;
    tick();
    wb_we = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'd0;
    md_waddr = 5'd13; md_wdata = 32'hA3;
    #1;
    total++; if (md_ready !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'hA1) begin
      bad++; $display("FAIL full_head got=%0h/%0h/%0d/%0h exp=0/1/11/a1", md_ready, rf_we, rf_waddr, rf_wdata); end
    tick();
    total++; if (md_ready !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hA2) begin
      bad++; $display("FAIL full_second got=%0h/%0h/%0d/%0h exp=1/1/12/a2", md_ready, rf_we, rf_waddr, rf_wdata); end
    tick();
    md_valid = 1'b0; md_waddr = 5'd0; md_wdata = 32'd0;
    #1;
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd13 || rf_wdata !== 32'hA3) begin
      bad++; $display("FAIL full_new got=%0h/%0d/%0h exp=1/13/a3", rf_we, rf_waddr, rf_wdata); end
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL full_drained got=%0h exp=0", rf_we); end
  endtask

  initial begin
    idle();
    test_reset();
    test_md_basic();
    test_md_zero();
    test_starve();
    test_reset_mid();
    test_wb_zero();
    test_full_order();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, consecutive blocked cycles before stall request; legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports wb_we / wb_waddr / wb_wdata  input  1/5/32  pipeline writeback request; always accepted, never back-pressured.
REQ-005 SHALL have ports md_valid / md_waddr / md_wdata  input  1/5/32  mul/div result offer.
REQ-006 SHALL have port md_ready  output  1  buffer can accept an md result this cycle.
REQ-007 SHALL have ports rf_we / rf_waddr / rf_wdata  output  1/5/32  single register-file write port.
REQ-008 SHALL have ports raddr1 / raddr2  input  5/5  decode-stage read addresses for pending check.
REQ-009 SHALL have ports pend1 / pend2  output  1/1  raddrN has an undelivered md result.
REQ-010 SHALL have port stall_o  output  1  request to pipeline to insert a writeback bubble.

Function
REQ-011 SHALL treat a wb or md request with waddr==0 as no write; md requests with waddr 0 are accepted and discarded.
REQ-012 SHALL hold md results in a 2-entry FIFO; md_ready = FIFO not full; enqueue on md_valid && md_ready.
REQ-013 SHALL grant the write port to wb whenever wb_we && wb_waddr!=0; rf_* then equals wb_* combinationally.
REQ-014 SHALL otherwise, if FIFO non-empty, drive rf_we=1 with FIFO head and dequeue it at that edge.
REQ-015 SHALL drive rf_we=0 when neither source writes; rf_waddr/rf_wdata then 0.
REQ-016 SHALL give a buffered md result minimum latency 1 cycle (enqueue edge to earliest rf_we cycle).
REQ-017 SHALL allow enqueue and dequeue in the same cycle; occupancy unchanged, FIFO order preserved.
REQ-018 SHALL wrap read/write pointers modulo 2; full=2 entries, empty=0; no enqueue when full, no dequeue when empty.
REQ-019 SHALL assert pendN when raddrN!=0 and equals waddr of any valid FIFO entry; entry being dequeued this cycle still counts.
REQ-020 SHALL keep a 4-bit starve_cnt: +1 (saturating at 15) each cycle FIFO non-empty and wb wins; cleared on any dequeue or when FIFO empty.
REQ-021 SHALL drive stall_o = (starve_cnt >= STARVE_MAX), a purely registered-state output.
REQ-022 SHALL still give wb priority if wb_we is high while stall_o=1; stall_o is advisory.
REQ-023 SHALL not order wb and md writes to the same register; the pipeline avoids this via pend1/pend2.

Reset
REQ-024 SHALL on resetn low immediately empty FIFO, zero pointers and starve_cnt, discarding buffered results.
REQ-025 SHALL while resetn low drive rf_we=0, md_ready=0, pend1=pend2=0, stall_o=0 regardless of inputs.
REQ-026 SHALL accept md results from the first rising edge after resetn deasserts.

Configuration
REQ-027 SHALL with macro WB_ARB_BYPASS_EN defined: md result with FIFO empty and no wb write written directly to rf_* same cycle, not enqueued (latency 0, md_ready=1).
REQ-028 SHALL without WB_ARB_BYPASS_EN: every accepted md result enqueued, latency per REQ-016.

Verification
REQ-029 SHALL cover: md_valid, waddr=5, wdata=0x1234, wb idle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234 (same cycle with WB_ARB_BYPASS_EN).
REQ-030 SHALL cover: two md results (r3, r4) while wb writes every cycle -> md_ready=0 after 2nd; pend1=1 for raddr1=3; stall_o=1 after 4 blocked cycles.
REQ-031 SHALL cover: wb_we=1 waddr=0 with FIFO holding r7 -> FIFO head written to r7 that cycle.
REQ-032 SHALL cover: FIFO full, wb idle, md_valid held -> r-head written, same-edge enqueue, order r_a, r_b, r_new preserved.
REQ-033 SHALL cover: resetn low mid-stream with 2 entries and stall_o=1 -> all outputs 0 immediately; no buffered write after release.
